// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types and constants for the instruction-fetch
//                controller: controller state encoding, instruction width,
//                PC increment, NOP word and the FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Controller state. ST_FAULT is only reachable when the alignment
    // check (FETCH_ALIGN_CHECK_EN) is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam int          INST_W   = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0;

    // FIFO entry is {pc, inst}
    localparam int          ENTRY_W  = 32 + INST_W;

    // Word-align a byte address by clearing bits [1:0].
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small fetch buffer built as a shift register. New entries
//                enter at slot 0 and older ones move up, so the oldest entry
//                (the head) always sits at slot count-1 and is selected by a
//                mux on the occupancy count.
//  Ports       : clk_i, rst_n_i (async, active-low)
//                push_i / pop_i / flush_i  - flush wins over push and pop
//                wdata_i                    - entry to append
//                rdata_o                    - head entry, zero when empty
//                count_o                    - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_count <= '0;
        end else begin
            // Shifting on every push also handles push+pop when full: the
            // departing head falls off the top slot.
            if (push_i) begin
                r_mem[0] <= wdata_i;
                for (int i = 1; i < DEPTH; i++) begin
                    r_mem[i] <= r_mem[i-1];
                end
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head select: slot count-1, or zero when empty.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_count == CNT_W'(i + 1)) begin
                rdata_o = r_mem[i];
            end
        end
    end

    assign count_o = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch controller for a 2**ADDR_W x 32
//                combinational instruction ROM. Owns the PC, drives the ROM
//                chip enable / word address, buffers {pc, inst} pairs in a
//                small FIFO and offers the head to decode via valid/ready.
//                A redirect flushes the buffer and reloads the PC.
//  Config      : `define FETCH_ALIGN_CHECK_EN adds fault_o and a sticky
//                FAULT state entered on a misaligned redirect target.
//                Without it, target bits [1:0] are silently cleared.
//  Ports       : clk_i, rst_n_i        clock, async active-low reset
//                en_i                  fetch enable
//                redirect_i/_pc_i      flush + PC reload pulse and target
//                rom_ce_o/rom_addr_o   ROM enable and word address
//                rom_inst_i            ROM data (combinational)
//                valid_o/ready_i       decode handshake
//                inst_o/pc_o           head entry, zero when not valid
//                busy_o                not idle or buffer non-empty
//                fault_o               (optional) misaligned redirect seen
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = 6,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_inst_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic              busy_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              fault_o
`endif
);

    import fetch_ctrl_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e       r_state;
    logic [31:0]        r_pc;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_pop;
    logic               w_fetch;
    logic               w_room;

`ifdef FETCH_ALIGN_CHECK_EN
    logic               r_fault;
    logic               w_misalign;

    assign w_misalign = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign fault_o    = r_fault;
`endif

    assign valid_o = (w_count != '0);
    assign w_pop   = valid_o & ready_i;

    // A slot is available if the buffer is not full, or the head leaves
    // this same cycle.
    assign w_room  = (w_count < CNT_W'(FIFO_DEPTH)) | w_pop;
    assign w_fetch = (r_state == ST_FETCH) & ~redirect_i & w_room;

    assign rom_ce_o   = w_fetch;
    assign rom_addr_o = r_pc[ADDR_W+1:2];

    // The FIFO returns zero when empty, so head outputs are already zero
    // whenever valid_o is low.
    assign inst_o = valid_o ? w_head[INST_W-1:0]      : NOP_INST;
    assign pc_o   = valid_o ? w_head[ENTRY_W-1:INST_W] : 32'h0;
    assign busy_o = (r_state != ST_IDLE) | valid_o;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (ENTRY_W),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_fetch),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .wdata_i ({r_pc, rom_inst_i}),
        .rdata_o (w_head),
        .count_o (w_count)
    );

    // PC and controller state. A redirect reloads the PC but leaves the
    // state alone (except entering FAULT on a misaligned target).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else if (redirect_i) begin
            r_pc <= align_pc(redirect_pc_i);
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_misalign) begin
                r_fault <= 1'b1;
                r_state <= ST_FAULT;
            end
`endif
        end else begin
            if (w_fetch) begin
                r_pc <= r_pc + PC_STEP;
            end
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!en_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (en_i) begin
                        r_state <= ST_FETCH;
                    end else if (w_count == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. A queue-based model of
//                the fetch buffer and PC predicts every observable output
//                each cycle; scenario tasks add targeted checks on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int          ADDR_W = 6;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          ROM_N  = 2 ** ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              en_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [31:0]       rom_inst_i;
    logic              valid_o;
    logic              ready_i;
    logic [31:0]       inst_o;
    logic [31:0]       pc_o;
    logic              busy_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              fault_o;
`endif

    logic [31:0] rom [ROM_N];
    assign rom_inst_i = rom[rom_addr_o];

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(
        .RESET_PC      (RST_PC),
        .ADDR_W        (ADDR_W),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .rom_ce_o      (rom_ce_o),
        .rom_addr_o    (rom_addr_o),
        .rom_inst_i    (rom_inst_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .busy_o        (busy_o)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fault_o       (fault_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FAULT = 3;
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_fault;

    localparam logic [72:0] RESET_OBS = {1'b0, 32'h0, 32'h0, 1'b0, RST_PC[ADDR_W+1:2], 1'b0};

    task automatic m_reset();
        m_q.delete();
        m_pc    = RST_PC;
        m_mode  = M_IDLE;
        m_fault = 1'b0;
    endtask

    function automatic bit m_fetch_now();
        return (m_mode == M_RUN) && !redirect_i &&
               ((m_q.size() < DEPTH) || (m_q.size() > 0 && ready_i));
    endfunction

    // {valid, pc, inst, rom_ce, rom_addr, busy}
    function automatic logic [72:0] m_expect();
        logic [63:0] head;
        logic        v;
        logic        b;
        head = (m_q.size() > 0) ? m_q[0] : 64'd0;
        v    = (m_q.size() != 0);
        b    = (m_mode != M_IDLE) || v;
        return {v, head[63:32], head[31:0], m_fetch_now(), m_pc[ADDR_W+1:2], b};
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic m_step();
        int sz;
        bit pop;
        bit fetch;
        sz    = m_q.size();
        pop   = (sz > 0) && ready_i;
        fetch = m_fetch_now();
        if (redirect_i) begin
            m_q.delete();
            m_pc = redirect_pc_i & ~32'd3;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc_i[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_mode  = M_FAULT;
            end
`endif
        end else begin
            if (pop) void'(m_q.pop_front());
            if (fetch) begin
                m_q.push_back({m_pc, rom[m_pc[ADDR_W+1:2]]});
                m_pc = m_pc + 32'd4;
            end
            if (m_mode != M_FAULT) begin
                if (en_i)                          m_mode = M_RUN;
                else if (m_mode == M_RUN)          m_mode = M_DRAIN;
                else if (m_mode == M_DRAIN && sz == 0) m_mode = M_IDLE;
            end
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    function automatic logic [72:0] obs();
        return {valid_o, pc_o, inst_o, rom_ce_o, rom_addr_o, busy_o};
    endfunction

    task automatic set_in(input bit en, input bit rd, input logic [31:0] rpc, input bit rdy);
        en_i = en; redirect_i = rd; redirect_pc_i = rpc; ready_i = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_step();
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        set_in(0, 0, 32'h0, 0);
        m_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic load_ramp_rom();
        for (int k = 0; k < ROM_N; k++) rom[k] = 32'h1000_0000 + k;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n_i = 1'b0;
        set_in(1, 0, 32'h0, 1);
        m_reset();
        checks++;
        if (obs() !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), RESET_OBS);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++;
        if (fault_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault got=%b exp=0", fault_o);
        end
`endif
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(1, 0, 32'h0, 1);
            checks++;
            if (obs() !== m_expect()) begin
                errors++;
                $display("FAIL stream_model cyc=%0d got=%h exp=%h", i, obs(), m_expect());
            end
            if (i >= 2) begin
                checks++;
                if (!(valid_o === 1'b1 && pc_o === 32'((i - 2) * 4) &&
                      inst_o === 32'h1000_0000 + 32'(i - 2))) begin
                    errors++;
                    $display("FAIL stream_seq cyc=%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h",
                             i, valid_o, pc_o, inst_o, (i - 2) * 4, 32'h1000_0000 + 32'(i - 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_next;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 32'h0, 0);
            checks++;
            if (obs() !== m_expect()) begin
                errors++;
                $display("FAIL bp_stall_model cyc=%0d got=%h exp=%h", i, obs(), m_expect());
            end
            tick();
        end
        set_in(1, 0, 32'h0, 0);
        checks++;
        if (!(rom_ce_o === 1'b0 && rom_addr_o === 6'd2 && valid_o === 1'b1 && pc_o === 32'h0)) begin
            errors++;
            $display("FAIL bp_frozen got ce=%b addr=%0d pc=%h exp ce=0 addr=2 pc=0",
                     rom_ce_o, rom_addr_o, pc_o);
        end
        exp_next = 32'h0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 32'h0, 1);
            checks++;
            if (obs() !== m_expect()) begin
                errors++;
                $display("FAIL bp_release_model cyc=%0d got=%h exp=%h", i, obs(), m_expect());
            end
            if (valid_o === 1'b1) begin
                checks++;
                if (pc_o !== exp_next) begin
                    errors++;
                    $display("FAIL bp_order cyc=%0d got pc=%h exp pc=%h", i, pc_o, exp_next);
                end
                exp_next = exp_next + 32'd4;
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 32'h0, 0);
            tick();
        end
        set_in(1, 1, 32'h40, 1);
        checks++;
        if (!(obs() === m_expect() && valid_o === 1'b1 && rom_ce_o === 1'b0)) begin
            errors++;
            $display("FAIL redir_cycle got=%h exp=%h", obs(), m_expect());
        end
        tick();
        set_in(1, 0, 32'h0, 1);
        checks++;
        if (!(valid_o === 1'b0 && rom_addr_o === 6'd16 && obs() === m_expect())) begin
            errors++;
            $display("FAIL redir_flush got v=%b addr=%0d exp v=0 addr=16", valid_o, rom_addr_o);
        end
        tick();
        set_in(1, 0, 32'h0, 1);
        checks++;
        if (!(valid_o === 1'b1 && pc_o === 32'h40 && inst_o === rom[16])) begin
            errors++;
            $display("FAIL redir_target got v=%b pc=%h inst=%h exp pc=00000040 inst=%h",
                     valid_o, pc_o, inst_o, rom[16]);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_next;
        bit          seen;
        apply_reset();
        set_in(1, 1, 32'hF0, 1);
        tick();
        exp_next = 32'hF0;
        seen     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 32'h0, 1);
            checks++;
            if (obs() !== m_expect()) begin
                errors++;
                $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs(), m_expect());
            end
            if (valid_o === 1'b1) begin
                checks++;
                if (!(pc_o === exp_next &&
                      inst_o === 32'h1000_0000 + ((exp_next >> 2) & 32'h3F))) begin
                    errors++;
                    $display("FAIL wrap_seq cyc=%0d got pc=%h inst=%h exp pc=%h", i, pc_o, inst_o, exp_next);
                end
                if (exp_next == 32'h100) seen = 1'b1;
                exp_next = exp_next + 32'd4;
            end
            tick();
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL wrap_reached got last_pc=%h exp beyond 00000100", exp_next);
        end
    endtask

    task automatic test_drain();
        int pops;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 32'h0, 0);
            tick();
        end
        set_in(0, 0, 32'h0, 0);
        tick();
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 32'h0, 1);
            checks++;
            if (obs() !== m_expect()) begin
                errors++;
                $display("FAIL drain_model cyc=%0d got=%h exp=%h", i, obs(), m_expect());
            end
            if (valid_o === 1'b1) pops++;
            tick();
        end
        set_in(0, 0, 32'h0, 1);
        checks++;
        if (!(pops == 2 && busy_o === 1'b0 && valid_o === 1'b0)) begin
            errors++;
            $display("FAIL drain_idle got pops=%0d busy=%b exp pops=2 busy=0", pops, busy_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 32'h0, 1);
            tick();
        end
        set_in(1, 0, 32'h0, 1);
        checks++;
        if (!(busy_o === 1'b1 && valid_o === 1'b1)) begin
            errors++;
            $display("FAIL arst_precond got busy=%b v=%b exp 1 1", busy_o, valid_o);
        end
        #1 rst_n_i = 1'b0;
        #1;
        m_reset();
        checks++;
        if (obs() !== RESET_OBS) begin
            errors++;
            $display("FAIL arst_outputs got=%h exp=%h", obs(), RESET_OBS);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit          en, rd, rdy;
        for (int k = 0; k < ROM_N; k++) rom[k] = $urandom;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rpc = rpc & ~32'd3;
`endif
            set_in(en, rd, rpc, rdy);
            checks++;
            if (obs() !== m_expect()) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs(), m_expect());
            end
            tick();
        end
        load_ramp_rom();
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_fault();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 32'h0, 1);
            tick();
        end
        set_in(1, 1, 32'h42, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 32'h0, 1);
            checks++;
            if (!(fault_o === 1'b1 && valid_o === 1'b0 && rom_ce_o === 1'b0 &&
                  obs() === m_expect())) begin
                errors++;
                $display("FAIL fault_sticky cyc=%0d got fault=%b v=%b ce=%b exp 1 0 0",
                         i, fault_o, valid_o, rom_ce_o);
            end
            tick();
        end
        apply_reset();
        set_in(0, 0, 32'h0, 0);
        checks++;
        if (fault_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear got=%b exp=0", fault_o);
        end
    endtask
`endif

    initial begin
        load_ramp_rom();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_drain();
        test_async_reset();
        test_random();
`ifdef FETCH_ALIGN_CHECK_EN
        test_fault();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller that sequences the 64x32 combinational instruction ROM.
- Owns the PC, drives the ROM chip-enable and word address, and captures {pc, inst} pairs into a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the FIFO and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- ADDR_W, 6, ROM word-address width; ROM depth is 2**ADDR_W.
- FIFO_DEPTH, 2, fetch-buffer entries; legal values 2 or 4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- en_i  in  1  fetch enable from core control.
- redirect_i  in  1  one-cycle pulse: flush and reload the PC.
- redirect_pc_i  in  32  redirect target byte address.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  ADDR_W  ROM word address; equals pc_q[ADDR_W+1:2].
- rom_inst_i  in  32  ROM read data, combinational from rom_addr_o.
- valid_o  out  1  FIFO head valid.
- ready_i  in  1  decode accepts the head this cycle.
- inst_o  out  32  head instruction; 32'h0 when valid_o=0.
- pc_o  out  32  head PC; 32'h0 when valid_o=0.
- busy_o  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset values:
  - pc_q=RESET_PC, FIFO empty, state=IDLE.
  - rom_ce_o=0, rom_addr_o=RESET_PC[ADDR_W+1:2], valid_o=0, inst_o=0, pc_o=0, busy_o=0.
- States:
  - IDLE: no fetch. en_i=1 -> FETCH.
  - FETCH: en_i=0 -> DRAIN.
  - DRAIN: no fetch. en_i=1 -> FETCH. FIFO empty and en_i=0 -> IDLE.
- Fetch cycle:
  - fetch = (state==FETCH) & ~redirect_i & (count<FIFO_DEPTH | pop).
  - rom_ce_o = fetch (combinational).
  - On the edge: push {pc_q, rom_inst_i}; pc_q <= pc_q+4 (32-bit wrap; bits above ADDR_W+1 alias into the ROM).
- Pop: pop = valid_o & ready_i. Push and pop in the same cycle are allowed at any count, including full; count is unchanged.
- Outputs:
  - valid_o = (count!=0).
  - inst_o/pc_o come from FIFO flops through a mux on count; there is no combinational path from rom_inst_i.
- Latency:
  - en_i sampled high in IDLE at edge N -> first push at edge N+1 -> valid_o=1 after edge N+1.
  - Steady state with ready_i=1: one instruction per cycle.
- Redirect:
  - All FIFO entries are flushed on the edge; valid_o=0 for the following cycle.
  - pc_q <= {redirect_pc_i[31:2],2'b00}. No fetch in the redirect cycle. State is unchanged.
  - Redirect has priority over push.
  - A same-cycle pop still counts as accepted by decode; the remaining entries are dropped.
- Redirect in IDLE/DRAIN: only pc_q updates; the FIFO is flushed.
- Backpressure: with the FIFO full and ready_i=0, rom_ce_o=0 and pc_q holds; head outputs are stable.
- Reset mid-operation: all state returns to reset values immediately (async); no partial push survives.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra port fault_o (out, 1, reset 0).
  - redirect_i with redirect_pc_i[1:0]!=0 sets fault_o (sticky), flushes the FIFO and enters state FAULT.
  - FAULT: rom_ce_o=0, valid_o=0. Exited only by reset.
- Undefined: no fault_o port and no FAULT state; low address bits are silently cleared.

Decomposition:
- Shared defines header:
  - State encodings IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, FAULT=2'd3.
  - INST_W=32, PC_STEP=4, NOP_INST=32'h0.
- One sub-module, fetch_fifo (parameterised depth and width 64).
  - Ports: push, pop, flush, wdata, rdata, count.
  - Async active-low reset; flush has priority over push.

Test Plan:
- Reset then en_i=1 at cycle 0 with ready_i=1, ROM word k = 32'h1000_0000+k -> valid_o from cycle 2; pc_o 0,4,8,... and inst_o 32'h1000_0000, 32'h1000_0001, ... back-to-back.
- ready_i=0 for 5 cycles while fetching -> count saturates at FIFO_DEPTH, rom_ce_o=0, pc_q frozen at 8 (depth 2); release -> resumes with no dropped or duplicate PCs.
- redirect_i with redirect_pc_i=32'h40 while the FIFO holds 2 entries and ready_i=1 -> head accepted, other entry dropped, valid_o=0 next cycle, then pc_o=32'h40 with inst_o=ROM[16].
- Fetch until pc_q=32'hFC, continue -> rom_addr_o wraps 63->0, pc_o=32'h100 returns ROM[0].
- en_i=0 with 2 entries buffered -> DRAIN delivers both, then IDLE, busy_o=0; rst_n_i pulsed low mid-FETCH -> all outputs at reset values within the same cycle.
- FETCH_ALIGN_CHECK_EN defined, redirect_pc_i=32'h42 -> fault_o=1 and valid_o=0 held until reset.
